// File: rtl/half_fixed_bias_relu_packer.sv
// Bias-add + saturate + optional ReLU on a serial row stream, repacked MULTS-wide per output word.
// Latency: first output word one cycle after the last sample of a frame; a frame emits in HEIGHT/MULTS cycles.
// Backpressure: none; ping-pong banks absorb one frame while the previous one drains, downstream must accept.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid, in_data    serial upstream samples, one row per valid cycle
//   load_bias, bias_in   bias load window, MULTS bias words per cycle
//   out_valid, out_data  packed activations, out_data[0] holds the lower row index
//   frame_done           one-cycle pulse with the last word of each frame
module half_fixed_bias_relu_packer #(
  parameter int BITS   = 16,
  parameter int HEIGHT = 10,
  parameter int MULTS  = 2,
  parameter int RELU   = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [BITS-1:0] in_data,
  input  logic            load_bias,
  input  logic [BITS-1:0] bias_in [MULTS],
  output logic            out_valid,
  output logic [BITS-1:0] out_data [MULTS],
  output logic            frame_done
);

  localparam int WORDS = HEIGHT / MULTS;
  localparam int IW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int WW    = (WORDS > 1) ? $clog2(WORDS) : 1;

  localparam logic [IW-1:0]   IDX_LAST = IW'(HEIGHT - 1);
  localparam logic [WW-1:0]   W_LAST   = WW'(WORDS - 1);
  localparam logic [BITS-1:0] SAT_MAX  = {1'b0, {(BITS-1){1'b1}}};
  localparam logic [BITS-1:0] SAT_MIN  = {1'b1, {(BITS-1){1'b0}}};

  typedef enum logic {
    S_IDLE,
    S_EMIT
  } state_t;

  // ---------------------------------------------------------------
  // Bias registers
  // ---------------------------------------------------------------
  logic [BITS-1:0] bias [HEIGHT];
  logic [WW-1:0]   load_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      load_cnt <= '0;
      for (int i = 0; i < HEIGHT; i++) begin
        bias[i] <= '0;
      end
    end else if (load_bias) begin
      for (int k = 0; k < MULTS; k++) begin
        bias[IW'(int'(load_cnt) * MULTS + k)] <= bias_in[k];
      end
      load_cnt <= (load_cnt == W_LAST) ? '0 : load_cnt + 1'b1;
    end else begin
      load_cnt <= '0;
    end
  end

  // ---------------------------------------------------------------
  // Collect side: bias add, saturation, ReLU
  // ---------------------------------------------------------------
  logic [IW-1:0]   idx;
  logic            wbank;
  logic [1:0]      full;
  logic [1:0]      full_next;
  logic            collect;
  logic            collect_last;
  logic [BITS:0]   sum;
  logic [BITS-1:0] sat;
  logic [BITS-1:0] act;

  // Bias loading owns the cycle: samples arriving during a load window are dropped.
  assign collect      = in_valid && !load_bias;
  assign collect_last = collect && (idx == IDX_LAST);

  always_comb begin
    sum = {in_data[BITS-1], in_data} + {bias[idx][BITS-1], bias[idx]};
    // One guard bit is enough: overflow shows as the two top bits disagreeing,
    // and the guard bit gives the true sign of the unclamped sum.
    if (sum[BITS] != sum[BITS-1]) begin
      sat = sum[BITS] ? SAT_MIN : SAT_MAX;
    end else begin
      sat = sum[BITS-1:0];
    end
    act = sat;
    if ((RELU != 0) && sat[BITS-1]) begin
      act = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx   <= '0;
      wbank <= 1'b0;
      full  <= 2'b00;
    end else begin
      if (load_bias) begin
        idx <= '0;
      end else if (in_valid) begin
        idx <= collect_last ? '0 : idx + 1'b1;
        if (collect_last) begin
          wbank <= ~wbank;
        end
      end
      full <= full_next;
    end
  end

  // ---------------------------------------------------------------
  // Frame storage (data needs no reset: validity lives in the full flags)
  // ---------------------------------------------------------------
  logic [BITS-1:0] bank [2][HEIGHT];

  always_ff @(posedge clk) begin
    if (!rst && collect) begin
      bank[wbank][idx] <= act;
    end
  end

  // ---------------------------------------------------------------
  // Emit FSM
  // ---------------------------------------------------------------
  state_t        state;
  state_t        state_next;
  logic          rbank;
  logic          rbank_next;
  logic          rbank_oth;
  logic [WW-1:0] w;
  logic [WW-1:0] w_next;
  logic          emit_last;

  assign rbank_oth = ~rbank;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      rbank <= 1'b0;
      w     <= '0;
    end else begin
      state <= state_next;
      rbank <= rbank_next;
      w     <= w_next;
    end
  end

  always_comb begin
    state_next = state;
    rbank_next = rbank;
    w_next     = w;
    emit_last  = 1'b0;
    out_valid  = 1'b0;
    frame_done = 1'b0;
    for (int k = 0; k < MULTS; k++) begin
      out_data[k] = '0;
    end

    case (state)
      S_IDLE: begin
        if (|full) begin
          // Banks fill and drain in the same alternating order, so rbank is
          // normally the oldest full bank; fall back to the other one if not.
          state_next = S_EMIT;
          rbank_next = full[rbank] ? rbank : rbank_oth;
          w_next     = '0;
        end
      end

      S_EMIT: begin
        out_valid = 1'b1;
        for (int k = 0; k < MULTS; k++) begin
          out_data[k] = bank[rbank][IW'(int'(w) * MULTS + k)];
        end
        if (w == W_LAST) begin
          frame_done = 1'b1;
          emit_last  = 1'b1;
          rbank_next = rbank_oth;
          w_next     = '0;
          // Back-to-back burst if the next frame is already waiting.
          state_next = full[rbank_oth] ? S_EMIT : S_IDLE;
        end else begin
          w_next = w + 1'b1;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Clear of the drained bank and set of the freshly filled bank target
  // different banks, so both land in the same cycle.
  always_comb begin
    full_next = full;
    if (emit_last) begin
      full_next[rbank] = 1'b0;
    end
    if (collect_last) begin
      full_next[wbank] = 1'b1;
    end
  end

endmodule

// File: tb/tb_half_fixed_bias_relu_packer.sv
module tb_half_fixed_bias_relu_packer;

  localparam int H = 4;
  localparam int M = 2;
  localparam int W = H / M;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        load_bias = 1'b0;
  logic [15:0] bias_in [M];

  logic        ov1, fd1, ov0, fd0;
  logic [15:0] od1 [M];
  logic [15:0] od0 [M];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  half_fixed_bias_relu_packer #(.BITS(16), .HEIGHT(H), .MULTS(M), .RELU(1)) dut_r1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .load_bias(load_bias), .bias_in(bias_in),
    .out_valid(ov1), .out_data(od1), .frame_done(fd1)
  );

  half_fixed_bias_relu_packer #(.BITS(16), .HEIGHT(H), .MULTS(M), .RELU(0)) dut_r0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .load_bias(load_bias), .bias_in(bias_in),
    .out_valid(ov0), .out_data(od0), .frame_done(fd0)
  );

  typedef struct {
    logic [15:0] d0;
    logic [15:0] d1;
    logic        done;
    int          cyc;
  } exp_t;

  exp_t q1[$];
  exp_t q0[$];
  exp_t e1, e0;

  // Reference model state
  logic [15:0] mbias [H];
  int          lcnt = 0;
  logic [15:0] part[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] sat_add(input logic [15:0] d, input logic [15:0] b);
    int s;
    s = int'($signed(d)) + int'($signed(b));
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    return 16'(s);
  endfunction

  function automatic logic [15:0] relu(input logic [15:0] v);
    return v[15] ? 16'h0000 : v;
  endfunction

  // One clock of stimulus; the model is updated with what the DUT captures on the next edge.
  task automatic step(input logic lb, input logic [15:0] b0, input logic [15:0] b1,
                      input logic v, input logic [15:0] d);
    int   cap;
    exp_t e;
    @(negedge clk);
    rst        = 1'b0;
    load_bias  = lb;
    bias_in[0] = b0;
    bias_in[1] = b1;
    in_valid   = v;
    in_data    = d;
    cap        = cyc + 1;
    if (lb) begin
      mbias[lcnt*M]     = b0;
      mbias[lcnt*M + 1] = b1;
      lcnt = (lcnt + 1) % W;
      part.delete();
    end else begin
      lcnt = 0;
      if (v) begin
        part.push_back(sat_add(d, mbias[part.size()]));
        if (part.size() == H) begin
          for (int w = 0; w < W; w++) begin
            e.done = (w == W - 1);
            e.cyc  = cap + 1 + w;
            e.d0   = relu(part[w*M]);
            e.d1   = relu(part[w*M + 1]);
            q1.push_back(e);
            e.d0   = part[w*M];
            e.d1   = part[w*M + 1];
            q0.push_back(e);
          end
          part.delete();
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
  endtask

  task automatic frame4(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] c, input logic [15:0] d);
    step(1'b0, 16'h0, 16'h0, 1'b1, a);
    step(1'b0, 16'h0, 16'h0, 1'b1, b);
    step(1'b0, 16'h0, 16'h0, 1'b1, c);
    step(1'b0, 16'h0, 16'h0, 1'b1, d);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst       = 1'b1;
    load_bias = 1'b0;
    in_valid  = 1'b0;
    repeat (n - 1) @(negedge clk);
    for (int i = 0; i < H; i++) mbias[i] = 16'h0;
    part.delete();
    lcnt = 0;
  endtask

  function automatic logic [15:0] rand_val();
    case ($urandom_range(0, 3))
      0:       return 16'($urandom_range(0, 255));
      1:       return 16'h8000 | 16'($urandom_range(0, 255));
      default: return 16'($urandom);
    endcase
  endfunction

  // Monitors: one per DUT, popping the scoreboard whenever a word appears.
  always @(negedge clk) begin
    if (ov1) begin
      if (q1.size() == 0) begin
        chk("r1 word with empty scoreboard", ov1, 1'b0);
      end else begin
        e1 = q1.pop_front();
        chk("r1 out_data[0]", od1[0], e1.d0);
        chk("r1 out_data[1]", od1[1], e1.d1);
        chk("r1 frame_done", fd1, e1.done);
        chk("r1 word cycle", cyc, e1.cyc);
      end
    end else if (fd1) begin
      chk("r1 frame_done without out_valid", fd1, 1'b0);
    end
  end

  always @(negedge clk) begin
    if (ov0) begin
      if (q0.size() == 0) begin
        chk("r0 word with empty scoreboard", ov0, 1'b0);
      end else begin
        e0 = q0.pop_front();
        chk("r0 out_data[0]", od0[0], e0.d0);
        chk("r0 out_data[1]", od0[1], e0.d1);
        chk("r0 frame_done", fd0, e0.done);
        chk("r0 word cycle", cyc, e0.cyc);
      end
    end else if (fd0) begin
      chk("r0 frame_done without out_valid", fd0, 1'b0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    int n;
    int budget;
    bias_in[0] = '0;
    bias_in[1] = '0;
    for (int i = 0; i < H; i++) mbias[i] = 16'h0;

    do_reset(3);
    chk("reset out_valid r1", ov1, 1'b0);
    chk("reset out_data[0] r1", od1[0], 16'h0);
    chk("reset out_data[1] r1", od1[1], 16'h0);
    chk("reset frame_done r1", fd1, 1'b0);
    chk("reset out_valid r0", ov0, 1'b0);
    chk("reset frame_done r0", fd0, 1'b0);

    // Basic frame, zero bias, ReLU clamp on the negative sample
    frame4(16'h0100, 16'hFF00, 16'h0200, 16'h0000);
    idle(4);

    // Two-cycle bias load then all-ones input
    step(1'b1, 16'h0010, 16'h0020, 1'b0, 16'h0);
    step(1'b1, 16'h0030, 16'h0040, 1'b0, 16'h0);
    frame4(16'h0001, 16'h0001, 16'h0001, 16'h0001);
    idle(4);

    // Positive and negative saturation
    step(1'b1, 16'h7F00, 16'h8000, 1'b0, 16'h0);
    step(1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0);
    frame4(16'h0200, 16'hFFFF, 16'h0000, 16'h0000);
    idle(4);

    // Two frames with contiguous in_valid
    for (int i = 0; i < 2 * H; i++) step(1'b0, 16'h0, 16'h0, 1'b1, rand_val());
    idle(4);

    // Reset after a partial frame
    step(1'b0, 16'h0, 16'h0, 1'b1, 16'h1111);
    step(1'b0, 16'h0, 16'h0, 1'b1, 16'h2222);
    do_reset(1);
    frame4(16'h0005, 16'h0006, 16'h0007, 16'h0008);
    idle(4);

    // Bias load pulse discards a partial frame
    step(1'b0, 16'h0, 16'h0, 1'b1, 16'h3333);
    step(1'b0, 16'h0, 16'h0, 1'b1, 16'h4444);
    step(1'b0, 16'h0, 16'h0, 1'b1, 16'h5555);
    step(1'b1, 16'h0101, 16'hFE00, 1'b1, 16'h6666);
    frame4(16'h0002, 16'h0100, 16'h0003, 16'h0004);
    idle(4);

    // Randomized traffic: bias loads, gaps, interrupted frames
    for (int it = 0; it < 60; it++) begin
      r = $urandom_range(0, 9);
      if (r < 2) begin
        n = $urandom_range(1, 3);
        repeat (n) step(1'b1, rand_val(), rand_val(), 1'($urandom_range(0, 1)), rand_val());
      end else begin
        for (int s = 0; s < H; s++) begin
          if ($urandom_range(0, 3) == 0) step(1'b0, 16'h0, 16'h0, 1'b0, rand_val());
          if ($urandom_range(0, 29) == 0) step(1'b1, rand_val(), rand_val(), 1'b0, 16'h0);
          step(1'b0, 16'h0, 16'h0, 1'b1, rand_val());
        end
      end
    end

    idle(6);
    budget = 0;
    while ((q1.size() != 0 || q0.size() != 0) && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    chk("r1 scoreboard drained", 32'(q1.size()), 32'd0);
    chk("r0 scoreboard drained", 32'(q0.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
